sram_port_arbiter: RTL and testbench

Shares one SRAM-like memory port between instruction fetch (IF) and data access (MEM). Issues one transaction at a time through a 3-state FSM, with fixed data priority and a starvation guard for fetch. Drives a stall request to the pipeline controller while a requester is blocked. Sits between the IF/MEM stages and the external memory interface.

---
 rtl/sram_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access,
// one transaction at a time, with data priority and a fetch starvation guard.
module sram_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        stallreq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic starved;
  logic grant_data;
  logic grant_inst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      wstrb_q <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Data wins a tie unless fetch has already been passed over STARVE_LIMIT times.
  assign starved    = (cnt_q == CNT_W'(STARVE_LIMIT));
  assign grant_data = data_req & ~(inst_req & starved);
  assign grant_inst = inst_req & ~grant_data;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    wstrb_d      = wstrb_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    bus_req      = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_data) begin
          data_addr_ok = rst;
          state_d      = ADDR;
          owner_d      = 1'b1;
          wr_d         = data_wr;
          wstrb_d      = data_wstrb;
          addr_d       = data_addr;
          wdata_d      = data_wdata;
          if (!inst_req) begin
            cnt_d = '0;
          end else if (!starved) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (grant_inst) begin
          inst_addr_ok = rst;
          state_d      = ADDR;
          owner_d      = 1'b0;
          wr_d         = 1'b0;
          wstrb_d      = 4'd0;
          addr_d       = inst_addr;
          wdata_d      = 32'd0;
          cnt_d        = '0;
        end
      end
      ADDR: begin
        bus_req = 1'b1;
        if (bus_addr_ok) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus_data_ok) begin
          inst_data_ok = ~owner_q;
          data_data_ok = owner_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Gated by reset so the pipeline sees no stall while the arbiter is held.
    stallreq = rst & ((state_q != IDLE) |
                      (inst_req & ~inst_addr_ok) |
                      (data_req & ~data_addr_ok));
  end

  assign bus_wr     = wr_q;
  assign bus_wstrb  = wstrb_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_sram_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        stallreq;

  int errors = 0;
  int checks = 0;

  sram_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive_idle();
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
  endtask

  // Walks a granted transaction through ADDR and DATA in minimum time and
  // returns at the start of the next arbitration cycle.
  task automatic complete_txn(input logic keep_inst, input logic keep_data, input logic [31:0] rd);
    @(negedge clk);
    inst_req = inst_req & keep_inst;
    data_req = data_req & keep_data;
    bus_addr_ok = 1;
    @(negedge clk);
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = rd;
    @(negedge clk);
    bus_data_ok = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 0;
    inst_req = 1; data_req = 1; bus_data_ok = 1;
    @(negedge clk); #1;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_req: got %b expected 0", bus_req); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("[TB] FAIL reset_stallreq: got %b expected 0", stallreq); end
    checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin errors++; $display("[TB] FAIL reset_oks: got %b expected 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    checks++; if (bus_addr !== 32'd0 || bus_wr !== 1'b0 || bus_wstrb !== 4'd0) begin errors++; $display("[TB] FAIL reset_bus_fields: got addr=%h wr=%b wstrb=%h expected zeros", bus_addr, bus_wr, bus_wstrb); end
    @(negedge clk);
    drive_idle();
    rst = 1;
  endtask

  task automatic test_single_load();
    @(negedge clk);
    data_req = 1; data_addr = 32'h1000; data_wr = 0;
    #1;
    checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL load_addr_ok: got %b expected 1", data_addr_ok); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("[TB] FAIL load_stall_c0: got %b expected 0", stallreq); end
    @(negedge clk);
    data_req = 0; bus_addr_ok = 1;
    #1;
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h1000) begin errors++; $display("[TB] FAIL load_bus_c1: got req=%b addr=%h expected 1/00001000", bus_req, bus_addr); end
    checks++; if (stallreq !== 1'b1) begin errors++; $display("[TB] FAIL load_stall_c1: got %b expected 1", stallreq); end
    @(negedge clk);
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (data_data_ok !== 1'b1 || data_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL load_data_c2: got ok=%b rdata=%h expected 1/deadbeef", data_data_ok, data_rdata); end
    checks++; if (stallreq !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("[TB] FAIL load_c2_stall_req: got stall=%b req=%b expected 1/0", stallreq, bus_req); end
    @(negedge clk);
    bus_data_ok = 0;
    #1;
    checks++; if (stallreq !== 1'b0 || data_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL load_c3_idle: got stall=%b ok=%b expected 0/0", stallreq, data_data_ok); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h0000_0080;
    data_req = 1; data_addr = 32'h0000_1100; data_wr = 0;
    #1;
    checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin errors++; $display("[TB] FAIL simul_first_grant: got d=%b i=%b expected 1/0", data_addr_ok, inst_addr_ok); end
    checks++; if (stallreq !== 1'b1) begin errors++; $display("[TB] FAIL simul_stall: got %b expected 1", stallreq); end
    complete_txn(1'b1, 1'b0, 32'hAAAA_0001);
    #1;
    checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL simul_if_grant: got %b expected 1", inst_addr_ok); end
    @(negedge clk);
    inst_req = 0; bus_addr_ok = 1;
    #1;
    checks++; if (bus_addr !== 32'h80 || bus_wr !== 1'b0 || bus_wstrb !== 4'd0) begin errors++; $display("[TB] FAIL simul_if_bus: got addr=%h wr=%b wstrb=%h expected 00000080/0/0", bus_addr, bus_wr, bus_wstrb); end
    @(negedge clk);
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hCAFE_F00D;
    #1;
    checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL simul_if_data: got iok=%b dok=%b rdata=%h expected 1/0/cafef00d", inst_data_ok, data_data_ok, inst_rdata); end
    @(negedge clk);
    bus_data_ok = 0;
  endtask

  // Two full starvation windows: IF must win every fifth arbitration, which
  // also shows the counter restarting from zero after each IF grant.
  task automatic test_starvation();
    logic exp_if;
    @(negedge clk);
    for (int r = 0; r < 2 * (LIMIT + 1); r++) begin
      inst_req = 1; inst_addr = 32'h100 + 32'(r) * 4;
      data_req = 1; data_addr = 32'h3000 + 32'(r) * 4;
      #1;
      exp_if = ((r % (LIMIT + 1)) == LIMIT);
      checks++; if (inst_addr_ok !== exp_if || data_addr_ok !== !exp_if) begin errors++; $display("[TB] FAIL starve_round%0d: got i=%b d=%b expected i=%b d=%b", r, inst_addr_ok, data_addr_ok, exp_if, !exp_if); end
      complete_txn(1'b1, exp_if, 32'h5000 + 32'(r));
    end
    drive_idle();
  endtask

  task automatic test_store_stable();
    @(negedge clk);
    data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_wdata = 32'h12345678; data_addr = 32'h2004;
    #1;
    checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL store_grant: got %b expected 1", data_addr_ok); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_idle();
      #1;
      checks++; if (bus_req !== 1'b1 || bus_wr !== 1'b1 || bus_wstrb !== 4'hF || bus_wdata !== 32'h12345678 || bus_addr !== 32'h2004) begin errors++; $display("[TB] FAIL store_hold%0d: got req=%b wr=%b wstrb=%h wdata=%h addr=%h expected 1/1/f/12345678/00002004", c, bus_req, bus_wr, bus_wstrb, bus_wdata, bus_addr); end
    end
    @(negedge clk);
    bus_addr_ok = 1;
    @(negedge clk);
    bus_addr_ok = 0; bus_data_ok = 1;
    #1;
    checks++; if (data_data_ok !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("[TB] FAIL store_done: got ok=%b req=%b expected 1/0", data_data_ok, bus_req); end
    @(negedge clk);
    bus_data_ok = 0;
    #1;
    checks++; if (data_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL store_ok_pulse: got %b expected 0", data_data_ok); end
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h400;
    #1;
    checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL stray_grant: got %b expected 1", inst_addr_ok); end
    @(negedge clk);
    inst_req = 0; bus_data_ok = 1; bus_rdata = 32'h1111_2222;
    #1;
    checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL stray_no_ok: got i=%b d=%b expected 0/0", inst_data_ok, data_data_ok); end
    @(negedge clk);
    bus_data_ok = 0;
    #1;
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h400) begin errors++; $display("[TB] FAIL stray_still_addr: got req=%b addr=%h expected 1/00000400", bus_req, bus_addr); end
    complete_txn(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h600;
    data_req = 1; data_addr = 32'h7000; data_wr = 0;
    @(negedge clk);
    data_req = 0; bus_addr_ok = 1;
    @(negedge clk);
    bus_addr_ok = 0; data_req = 1; data_addr = 32'h7100;
    rst = 0; bus_data_ok = 1;
    #1;
    checks++; if (bus_req !== 1'b0 || stallreq !== 1'b0) begin errors++; $display("[TB] FAIL midrst_req_stall: got req=%b stall=%b expected 0/0", bus_req, stallreq); end
    checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin errors++; $display("[TB] FAIL midrst_oks: got %b expected 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    @(negedge clk);
    bus_data_ok = 0;
    rst = 1;
    #1;
    checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin errors++; $display("[TB] FAIL midrst_regrant: got d=%b i=%b expected 1/0", data_addr_ok, inst_addr_ok); end
    complete_txn(1'b1, 1'b0, 32'h0);
    #1;
    checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL midrst_if_next: got %b expected 1", inst_addr_ok); end
    complete_txn(1'b0, 1'b0, 32'h0);
    drive_idle();
  endtask

  // Randomized traffic against a transaction-level model: requesters hold
  // their request until accepted, the memory port acks at random.
  task automatic test_random();
    int          phase = 0;
    int          streak = 0;
    logic        own_mem = 0, m_wr = 0;
    logic [3:0]  m_wstrb = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic        ip = 0, dp = 0;
    logic        e_ia, e_da, e_id, e_dd, e_stall;
    @(negedge clk);
    drive_idle();
    rst = 0;
    @(negedge clk);
    rst = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!ip && ($urandom % 3 != 0)) begin ip = 1; inst_addr = $urandom & 32'hFFFF_FFFC; end
      if (!dp && ($urandom % 2 == 0)) begin
        dp = 1; data_addr = $urandom; data_wr = $urandom % 2;
        data_wstrb = 4'($urandom); data_wdata = $urandom;
      end
      inst_req = ip; data_req = dp;
      bus_addr_ok = ($urandom % 3 == 0);
      bus_data_ok = ($urandom % 3 == 0);
      bus_rdata = $urandom;
      e_ia = 0; e_da = 0; e_id = 0; e_dd = 0;
      if (phase == 0) begin
        if (dp && !(ip && streak == LIMIT)) e_da = 1;
        else if (ip) e_ia = 1;
      end
      if (phase == 2 && bus_data_ok) begin e_id = !own_mem; e_dd = own_mem; end
      e_stall = (phase != 0) || (ip && !e_ia) || (dp && !e_da);
      #1;
      checks++; if (inst_addr_ok !== e_ia || data_addr_ok !== e_da) begin errors++; $display("[TB] FAIL rnd_addr_ok cyc%0d: got i=%b d=%b expected i=%b d=%b", cyc, inst_addr_ok, data_addr_ok, e_ia, e_da); end
      checks++; if (inst_data_ok !== e_id || data_data_ok !== e_dd) begin errors++; $display("[TB] FAIL rnd_data_ok cyc%0d: got i=%b d=%b expected i=%b d=%b", cyc, inst_data_ok, data_data_ok, e_id, e_dd); end
      checks++; if (bus_req !== (phase == 1)) begin errors++; $display("[TB] FAIL rnd_bus_req cyc%0d: got %b expected %b", cyc, bus_req, phase == 1); end
      checks++; if (stallreq !== e_stall) begin errors++; $display("[TB] FAIL rnd_stall cyc%0d: got %b expected %b", cyc, stallreq, e_stall); end
      if (phase == 1) begin
        checks++; if (bus_addr !== m_addr || bus_wr !== m_wr || bus_wstrb !== m_wstrb || (m_wr && bus_wdata !== m_wdata)) begin errors++; $display("[TB] FAIL rnd_bus_fields cyc%0d: got %h/%b/%h/%h expected %h/%b/%h/%h", cyc, bus_addr, bus_wr, bus_wstrb, bus_wdata, m_addr, m_wr, m_wstrb, m_wdata); end
      end
      if (e_id) begin
        checks++; if (inst_rdata !== bus_rdata) begin errors++; $display("[TB] FAIL rnd_inst_rdata cyc%0d: got %h expected %h", cyc, inst_rdata, bus_rdata); end
      end
      if (e_dd && !m_wr) begin
        checks++; if (data_rdata !== bus_rdata) begin errors++; $display("[TB] FAIL rnd_data_rdata cyc%0d: got %h expected %h", cyc, data_rdata, bus_rdata); end
      end
      case (phase)
        0: if (e_da) begin
             phase = 1; own_mem = 1; m_addr = data_addr; m_wr = data_wr;
             m_wstrb = data_wstrb; m_wdata = data_wdata;
             streak = ip ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
             dp = 0;
           end else if (e_ia) begin
             phase = 1; own_mem = 0; m_addr = inst_addr; m_wr = 0; m_wstrb = 0;
             streak = 0; ip = 0;
           end
        1: if (bus_addr_ok) phase = 2;
        default: if (bus_data_ok) phase = 0;
      endcase
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rst = 0;
    test_reset();
    test_single_load();
    test_simultaneous();
    test_starvation();
    test_store_stable();
    test_stray_ack();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
